mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the MEM-stage data access (DM) of the 5-stage pipeline.
- Arbitrates with fixed DM priority plus a starvation guard for IF.
- Sequences each memory transaction through a request/grant/response handshake with one transaction outstanding.
- Generates stall_if and stall_mem for the pipeline control logic.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width
- MAX_DM_STREAK, 4, max consecutive DM grants while IF waits (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_WIDTH  fetch address
- if_flush  in  1  discard any in-flight fetch response
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_WIDTH  fetch data, valid with if_ack
- dm_req  in  1  data request, level
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_be  in  DATA_WIDTH/8  store byte enables
- dm_ack  out  1  one-cycle data completion pulse
- dm_rdata  out  DATA_WIDTH  load data, valid with dm_ack
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  response valid, for reads and writes
- mem_rdata  in  DATA_WIDTH  response data
- stall_if  out  1  IF must hold
- stall_mem  out  1  MEM must hold

Behaviour:
- Reset (rst_n low at posedge): state = IDLE, streak = 0, flush_pending = 0.
  - All registered outputs (mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, dm_ack, if_rdata, dm_rdata) = 0.
  - Reset mid-transaction abandons it. Any later mem_rvalid is ignored because it arrives in IDLE.
- States: IDLE, REQ_IF, REQ_DM, WAIT_IF, WAIT_DM.
- Requester rule: req and payload are held stable from assertion until the ack pulse. The requester deasserts req in the ack cycle or later.
- IDLE arbitration, evaluated every cycle:
  - dm_req & ~(if_req & streak == MAX_DM_STREAK) -> REQ_DM.
  - else if_req -> REQ_IF.
  - Payload is latched into the mem_* registers on the transition.
  - IF transactions: mem_we = 0, mem_be = all ones, mem_wdata = 0.
- Streak counter:
  - On a DM grant with if_req high: streak + 1, saturating at MAX_DM_STREAK.
  - On an IF grant, or when if_req is low in IDLE: streak = 0.
- REQ_x: mem_req = 1, payload held. On mem_gnt: mem_req <= 0 and go to WAIT_x. mem_req is never withdrawn before grant.
- WAIT_x: on mem_rvalid, next cycle:
  - x_ack = 1 for exactly one cycle.
  - x_rdata = registered mem_rdata (stores return rvalid; their rdata is don't-care).
  - State returns to IDLE.
- Latency: mem_gnt same-cycle and mem_rvalid the cycle after grant gives req at cycle 0, mem_req at cycle 1, rvalid at cycle 2, ack at cycle 3. Back-to-back transactions restart arbitration in IDLE on the ack cycle.
- mem_rvalid or mem_gnt in a state that does not expect it (IDLE, or mem_rvalid in REQ_x): ignored.
- if_flush:
  - In REQ_IF or WAIT_IF it sets flush_pending. The transaction completes on the memory side, but if_ack is suppressed and if_rdata is left unchanged.
  - flush_pending clears on return to IDLE.
  - In other states if_flush has no effect.
- stall_if = if_req & ~if_ack; stall_mem = dm_req & ~dm_ack. Both combinational, 0 while rst_n is low.
- if_ack and dm_ack are never asserted in the same cycle.

Test Plan:
- Single load: dm_req = 1, dm_addr = 0x100, we = 0; memory gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF -> mem_req high only in cycle 1; dm_ack pulses in cycle 3 with dm_rdata = 0xDEADBEEF; stall_mem high in cycles 0-2.
- Simultaneous if_req and dm_req from IDLE -> DM granted first (mem_addr = dm_addr, mem_we = dm_we); IF granted after dm_ack; if_ack follows with fetched data.
- Starvation guard: if_req held high, dm_req high continuously, MAX_DM_STREAK = 4 -> 4 DM transactions, then one IF transaction; streak resets afterwards.
- Grant backpressure: mem_gnt held low 5 cycles -> mem_req and payload stable for all 5 cycles; no ack until rvalid.
- Flush: if_flush pulsed while in WAIT_IF; rvalid returns 0x13 -> no if_ack; if_rdata unchanged; arbiter returns to IDLE and serves the next request normally.
- Reset mid-op: rst_n low during WAIT_DM, then mem_rvalid arrives after reset releases -> all outputs 0; no dm_ack; state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and MEM-stage data
// accesses: data side has priority, with a streak limit so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic                    dm_ack,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_if,
  output logic                    stall_mem
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_IF  = 3'd1,
    REQ_DM  = 3'd2,
    WAIT_IF = 3'd3,
    WAIT_DM = 3'd4
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                flush_pending;
  logic                if_starved;
  logic                dm_wins;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == STREAK_MAX) ? v : v + 1'b1;
  endfunction

  // Fetch overrides data priority once it has watched MAX_DM_STREAK data grants.
  assign if_starved = if_req & (streak == STREAK_MAX);
  assign dm_wins    = dm_req & ~if_starved;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      streak        <= '0;
      flush_pending <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      if_ack        <= 1'b0;
      dm_ack        <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          flush_pending <= 1'b0;
          if (dm_wins) begin
            state     <= REQ_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            streak    <= if_req ? sat_inc(streak) : '0;
          end else begin
            streak <= '0;
            if (if_req) begin
              state     <= REQ_IF;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= '1;
            end
          end
        end
        REQ_IF: begin
          if (if_flush) flush_pending <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT_IF;
          end
        end
        REQ_DM: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT_DM;
          end
        end
        WAIT_IF: begin
          if (mem_rvalid) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            // A flushed fetch still drains from memory but is never reported.
            if (!flush_pending && !if_flush) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            flush_pending <= 1'b1;
          end
        end
        WAIT_DM: begin
          if (mem_rvalid) begin
            state    <= IDLE;
            dm_ack   <= 1'b1;
            dm_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_if  = rst_n & if_req & ~if_ack;
  assign stall_mem = rst_n & dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queued requesters, a programmable memory
// responder and a transaction-level reference checked every cycle.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [BW-1:0] dm_be = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_if;
  logic          stall_mem;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] resp_for(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    if (a == 32'h200) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Requesters: each presents the head of its queue until acked, then the next.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } dreq_t;
  dreq_t         dm_q[$];
  logic [AW-1:0] if_q[$];

  always @(posedge clk) begin
    #1;
    if (dm_ack && dm_q.size() != 0) void'(dm_q.pop_front());
    if (dm_q.size() != 0) begin
      dm_req   = 1'b1;
      dm_we    = dm_q[0].we;
      dm_addr  = dm_q[0].addr;
      dm_wdata = dm_q[0].wdata;
      dm_be    = dm_q[0].be;
    end else begin
      dm_req = 1'b0;
    end
    if (if_ack && if_q.size() != 0) void'(if_q.pop_front());
    if (if_q.size() != 0) begin
      if_req  = 1'b1;
      if_addr = if_q[0];
    end else begin
      if_req = 1'b0;
    end
  end

  // Memory: grant after gnt_delay cycles of mem_req, respond rv_delay cycles after the grant cycle's successor.
  int            gnt_delay = 0;
  int            rv_delay = 0;
  int            gcnt = 0;
  int            rv_cnt = 0;
  bit            rv_pend = 1'b0;
  logic [DW-1:0] rv_data = '0;

  always @(posedge clk) begin
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
        rv_pend    = 1'b0;
      end else begin
        rv_cnt--;
      end
    end
    if (mem_req && !rv_pend) begin
      if (gcnt >= gnt_delay) begin
        mem_gnt = 1'b1;
        gcnt    = 0;
        rv_pend = 1'b1;
        rv_cnt  = rv_delay;
        rv_data = resp_for(mem_addr);
      end else begin
        gcnt++;
      end
    end else begin
      gcnt = 0;
    end
  end

  // Reference: one transaction "owner" at a time; it is either waiting for
  // acceptance or waiting for its response.
  int            m_owner = 0;  // 0 none, 1 fetch, 2 data
  bit            m_accepted = 1'b0;
  bit            m_flushed = 1'b0;
  int            m_streak = 0;
  bit            model_live = 1'b0;
  logic          e_mem_req = 1'b0, e_mem_we = 1'b0, e_if_ack = 1'b0, e_dm_ack = 1'b0;
  logic [AW-1:0] e_mem_addr = '0;
  logic [DW-1:0] e_mem_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;
  logic [BW-1:0] e_mem_be = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_live = 1'b1;
      m_owner = 0; m_accepted = 1'b0; m_flushed = 1'b0; m_streak = 0;
      e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_be = '0;
      e_if_ack = 1'b0; e_dm_ack = 1'b0; e_if_rdata = '0; e_dm_rdata = '0;
    end else begin
      e_if_ack = 1'b0;
      e_dm_ack = 1'b0;
      if (m_owner == 0) begin
        m_flushed = 1'b0;
        if (dm_req && !(if_req && m_streak >= MAXS)) begin
          m_owner = 2; m_accepted = 1'b0;
          e_mem_we = dm_we; e_mem_addr = dm_addr; e_mem_wdata = dm_wdata; e_mem_be = dm_be;
          m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else begin
          m_streak = 0;
          if (if_req) begin
            m_owner = 1; m_accepted = 1'b0;
            e_mem_we = 1'b0; e_mem_addr = if_addr; e_mem_wdata = '0; e_mem_be = '1;
          end
        end
      end else if (!m_accepted) begin
        if (m_owner == 1 && if_flush) m_flushed = 1'b1;
        if (mem_gnt) m_accepted = 1'b1;
      end else if (mem_rvalid) begin
        if (m_owner == 2) begin
          e_dm_ack = 1'b1; e_dm_rdata = mem_rdata;
        end else if (!m_flushed && !if_flush) begin
          e_if_ack = 1'b1; e_if_rdata = mem_rdata;
        end
        m_owner = 0;
      end else if (m_owner == 1 && if_flush) begin
        m_flushed = 1'b1;
      end
      e_mem_req = (m_owner != 0) && !m_accepted;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk1("mem_req", mem_req, e_mem_req);
      chk1("mem_we", mem_we, e_mem_we);
      chk32("mem_addr", mem_addr, e_mem_addr);
      chk32("mem_wdata", mem_wdata, e_mem_wdata);
      chk32("mem_be", 32'(mem_be), 32'(e_mem_be));
      chk1("if_ack", if_ack, e_if_ack);
      chk1("dm_ack", dm_ack, e_dm_ack);
      chk32("if_rdata", if_rdata, e_if_rdata);
      chk32("dm_rdata", dm_rdata, e_dm_rdata);
      chk1("stall_if", stall_if, rst_n & if_req & ~e_if_ack);
      chk1("stall_mem", stall_mem, rst_n & dm_req & ~e_dm_ack);
      chk1("ack_exclusive", if_ack & dm_ack, 1'b0);
    end
  end

  int ack_log[$];  // 1 = data ack, 2 = fetch ack
  always @(negedge clk) begin
    if (dm_ack) ack_log.push_back(1);
    if (if_ack) ack_log.push_back(2);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((dm_q.size() != 0 || if_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (dm_q.size() != 0 || if_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d data and %0d fetch requests still pending, required 0",
               name, dm_q.size(), if_q.size());
    end
    repeat (2) step();
  endtask

  task automatic wait_mem_req(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk1({name, "_mem_req_seen"}, mem_req, 1'b1);
  endtask

  initial begin
    int order_exp[11];
    order_exp = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1};

    // Reset with a fetch already pending: nothing may move, stalls held low.
    if_q.push_back(32'h40);
    repeat (3) @(negedge clk);
    chk1("rst_stall_if", stall_if, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_be", 32'(mem_be), 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_dm_rdata", dm_rdata, 32'h0);
    chk1("rst_if_ack", if_ack, 1'b0);
    step();
    rst_n = 1'b1;
    wait_done("boot_fetch", 20);
    chk32("boot_if_rdata", if_rdata, 32'h5A5A_0040);

    // Single load, cycle-exact.
    dm_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
    @(negedge clk);
    @(negedge clk);
    chk1("ld_c0_stall_mem", stall_mem, 1'b1);
    chk1("ld_c0_mem_req", mem_req, 1'b0);
    @(negedge clk);
    chk1("ld_c1_mem_req", mem_req, 1'b1);
    chk32("ld_c1_mem_addr", mem_addr, 32'h100);
    chk1("ld_c1_mem_we", mem_we, 1'b0);
    chk1("ld_c1_stall_mem", stall_mem, 1'b1);
    @(negedge clk);
    chk1("ld_c2_mem_req", mem_req, 1'b0);
    chk1("ld_c2_dm_ack", dm_ack, 1'b0);
    chk1("ld_c2_stall_mem", stall_mem, 1'b1);
    @(negedge clk);
    chk1("ld_c3_dm_ack", dm_ack, 1'b1);
    chk32("ld_c3_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk1("ld_c3_stall_mem", stall_mem, 1'b0);
    @(negedge clk);
    chk1("ld_c4_dm_ack", dm_ack, 1'b0);
    wait_done("single_load", 10);

    // Simultaneous requests: data first, then fetch.
    ack_log.delete();
    if_q.push_back(32'h400);
    dm_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h1122_3344, be: 4'b0011});
    wait_mem_req("sim", 10);
    chk32("sim_first_addr", mem_addr, 32'h300);
    chk1("sim_first_we", mem_we, 1'b1);
    chk32("sim_first_be", 32'(mem_be), 32'h3);
    chk32("sim_first_wdata", mem_wdata, 32'h1122_3344);
    wait_done("simultaneous", 30);
    chk32("sim_order_len", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      chk32("sim_order_0", 32'(ack_log[0]), 32'd1);
      chk32("sim_order_1", 32'(ack_log[1]), 32'd2);
    end
    chk32("sim_if_rdata", if_rdata, 32'h5A5A_0400);

    // Starvation guard: four data grants, one fetch, streak restarts.
    ack_log.delete();
    for (int i = 0; i < 9; i++)
      dm_q.push_back('{we: 1'b0, addr: 32'h1000 + 32'(i * 4), wdata: 32'h0, be: 4'hF});
    if_q.push_back(32'h2000);
    if_q.push_back(32'h2004);
    wait_done("starvation", 200);
    chk32("starv_order_len", 32'(ack_log.size()), 32'd11);
    if (ack_log.size() == 11)
      for (int i = 0; i < 11; i++)
        chk32($sformatf("starv_order_%0d", i), 32'(ack_log[i]), 32'(order_exp[i]));
    chk32("starv_if_rdata", if_rdata, 32'h5A5A_2004);

    // Grant backpressure: five cycles without mem_gnt.
    gnt_delay = 5;
    dm_q.push_back('{we: 1'b1, addr: 32'h500, wdata: 32'hCAFE_F00D, be: 4'b1100});
    wait_mem_req("bp", 10);
    for (int i = 0; i < 6; i++) begin
      chk1($sformatf("bp_mem_req_%0d", i), mem_req, 1'b1);
      chk32($sformatf("bp_mem_addr_%0d", i), mem_addr, 32'h500);
      chk32($sformatf("bp_mem_wdata_%0d", i), mem_wdata, 32'hCAFE_F00D);
      chk32($sformatf("bp_mem_be_%0d", i), 32'(mem_be), 32'hC);
      chk1($sformatf("bp_dm_ack_%0d", i), dm_ack, 1'b0);
      if (i < 5) @(negedge clk);
    end
    @(negedge clk);
    chk1("bp_after_gnt_mem_req", mem_req, 1'b0);
    chk1("bp_after_gnt_dm_ack", dm_ack, 1'b0);
    @(negedge clk);
    chk1("bp_dm_ack", dm_ack, 1'b1);
    gnt_delay = 0;
    wait_done("backpressure", 10);

    // Flush while waiting for a fetch response.
    rv_delay = 3;
    if_q.push_back(32'h200);
    wait_mem_req("fl", 10);
    step();
    step();
    if_flush = 1'b1;
    if_q.delete();
    step();
    if_flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1($sformatf("fl_if_ack_%0d", i), if_ack, 1'b0);
      chk32($sformatf("fl_if_rdata_%0d", i), if_rdata, 32'h5A5A_2004);
    end
    rv_delay = 0;
    ack_log.delete();
    if_q.push_back(32'h600);
    wait_done("after_flush", 20);
    chk32("fl_next_if_rdata", if_rdata, 32'h5A5A_0600);
    chk32("fl_next_acks", 32'(ack_log.size()), 32'd1);

    // Reset during WAIT_DM; the late response must be ignored.
    rv_delay = 4;
    dm_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'h0, be: 4'hF});
    wait_mem_req("rs", 10);
    step();
    step();
    rst_n = 1'b0;
    dm_q.delete();
    @(negedge clk);
    chk1("rs_stall_mem_in_reset", stall_mem, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1($sformatf("rs_dm_ack_%0d", i), dm_ack, 1'b0);
      chk1($sformatf("rs_mem_req_%0d", i), mem_req, 1'b0);
      chk32($sformatf("rs_mem_addr_%0d", i), mem_addr, 32'h0);
      chk32($sformatf("rs_dm_rdata_%0d", i), dm_rdata, 32'h0);
      chk32($sformatf("rs_if_rdata_%0d", i), if_rdata, 32'h0);
    end
    rv_delay = 0;
    dm_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
    wait_done("after_reset", 20);
    chk32("rs_next_dm_rdata", dm_rdata, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
